// File: rtl/vga_plot_arbiter.sv
// vga_plot_arbiter: registers one winning pixel per cycle onto the VGA adapter port, round-robin
// between two producers; the full-screen clear sweep exists only when VGA_ARB_CLEAR_EN is defined.
`ifndef X_BITES
`define X_BITES 8
`endif
`ifndef Y_BITES
`define Y_BITES 7
`endif
`ifndef COLOR_BITES
`define COLOR_BITES 3
`endif

module vga_plot_arbiter #(
  parameter int                      SCREEN_W     = 160,
  parameter int                      SCREEN_H     = 120,
  parameter logic [`COLOR_BITES-1:0] CLEAR_COLOUR = '0
) (
  input  logic                    CLOCK_50,
  input  logic                    reset,
  input  logic                    req0_plot,
  input  logic [`X_BITES-1:0]     req0_x,
  input  logic [`Y_BITES-1:0]     req0_y,
  input  logic [`COLOR_BITES-1:0] req0_colour,
  output logic                    req0_ready,
  input  logic                    req1_plot,
  input  logic [`X_BITES-1:0]     req1_x,
  input  logic [`Y_BITES-1:0]     req1_y,
  input  logic [`COLOR_BITES-1:0] req1_colour,
  output logic                    req1_ready,
  input  logic                    clear_start,
  output logic                    clear_busy,
  output logic                    clear_done,
  output logic [`X_BITES-1:0]     x,
  output logic [`Y_BITES-1:0]     y,
  output logic [`COLOR_BITES-1:0] colour,
  output logic                    plot
);

  localparam int XW = `X_BITES;
  localparam int YW = `Y_BITES;
  localparam int CW = `COLOR_BITES;

  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

  state_t          state_q, state_d;
  logic            last_grant_q, last_grant_d;
  logic            plot_q, plot_d;
  logic [XW-1:0]   x_q, x_d;
  logic [YW-1:0]   y_q, y_d;
  logic [CW-1:0]   colour_q, colour_d;

`ifdef VGA_ARB_CLEAR_EN
  logic [XW-1:0]   cx_q, cx_d;
  logic [YW-1:0]   cy_q, cy_d;
  logic            clear_done_q, clear_done_d;
`else
  logic            unused_clear_start;
  assign unused_clear_start = clear_start;
`endif

  // Arbitration: a lone requester always wins; on contention the producer not granted last wins.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (state_q == IDLE) begin
      if (req0_plot && req1_plot) begin
        req0_ready = last_grant_q;
        req1_ready = ~last_grant_q;
      end else begin
        req0_ready = req0_plot;
        req1_ready = req1_plot;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    plot_d       = 1'b0;
    x_d          = x_q;
    y_d          = y_q;
    colour_d     = colour_q;
`ifdef VGA_ARB_CLEAR_EN
    cx_d         = cx_q;
    cy_d         = cy_q;
    clear_done_d = 1'b0;
`endif
    if (state_q == IDLE) begin
      if (req0_ready) begin
        plot_d       = 1'b1;
        x_d          = req0_x;
        y_d          = req0_y;
        colour_d     = req0_colour;
        last_grant_d = 1'b0;
      end else if (req1_ready) begin
        plot_d       = 1'b1;
        x_d          = req1_x;
        y_d          = req1_y;
        colour_d     = req1_colour;
        last_grant_d = 1'b1;
      end
`ifdef VGA_ARB_CLEAR_EN
      if (clear_start) begin
        state_d = CLEAR;
        cx_d    = '0;
        cy_d    = '0;
      end
`endif
    end else begin
`ifdef VGA_ARB_CLEAR_EN
      plot_d   = 1'b1;
      x_d      = cx_q;
      y_d      = cy_q;
      colour_d = CLEAR_COLOUR;
      // Explicit end-of-range compares so non-power-of-two screens wrap correctly.
      if (cx_q == XW'(SCREEN_W - 1)) begin
        cx_d = '0;
        if (cy_q == YW'(SCREEN_H - 1)) begin
          cy_d         = '0;
          state_d      = IDLE;
          clear_done_d = 1'b1;
        end else begin
          cy_d = cy_q + 1'b1;
        end
      end else begin
        cx_d = cx_q + 1'b1;
      end
`else
      state_d = IDLE;
`endif
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      plot_q       <= 1'b0;
      x_q          <= '0;
      y_q          <= '0;
      colour_q     <= '0;
`ifdef VGA_ARB_CLEAR_EN
      cx_q         <= '0;
      cy_q         <= '0;
      clear_done_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      plot_q       <= plot_d;
      x_q          <= x_d;
      y_q          <= y_d;
      colour_q     <= colour_d;
`ifdef VGA_ARB_CLEAR_EN
      cx_q         <= cx_d;
      cy_q         <= cy_d;
      clear_done_q <= clear_done_d;
`endif
    end
  end

  assign plot   = plot_q;
  assign x      = x_q;
  assign y      = y_q;
  assign colour = colour_q;

`ifdef VGA_ARB_CLEAR_EN
  assign clear_busy = (state_q == CLEAR);
  assign clear_done = clear_done_q;
`else
  assign clear_busy = 1'b0;
  assign clear_done = 1'b0;
`endif

endmodule
